rr_onehot_arbiter: RTL and testbench



---
 rtl/rr_onehot_arbiter_pkg.sv | 31 +++
 rtl/one_hot_to_bcd.sv | 15 +
 rtl/rr_onehot_arbiter.sv | 91 +++++++++
 tb/tb_rr_onehot_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared definitions for the round-robin one-hot arbiter: requester count,
// FSM state encoding, the default hold limit and the circular priority search.
package rr_onehot_arbiter_pkg;

  localparam int REQ_N        = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set request bit found by searching circularly upward from last+1.
  // The final candidate (i == REQ_N) wraps back to last itself.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [REQ_N-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= REQ_N; i++) begin
      cand = last + IDX_W'(i);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/one_hot_to_bcd.sv
// One-hot to BCD index encoder for an 8-bit vector; the result is only
// meaningful when exactly one input bit is set.
module one_hot_to_bcd (
  input  logic [7:0] onehot,
  output logic [3:0] bcd
);

  always_comb begin
    bcd = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) bcd = bcd | 4'(i);
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter for 8 requesters with a bounded hold time, one-hot
// registered grant, BCD grant index and a forced-release pulse.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] req,
  output logic [REQ_N-1:0] grant,
  output logic [3:0]       grant_idx,
  output logic             grant_valid,
  output logic             expired
);

  arb_state_e       state_q, state_d;
  logic [REQ_N-1:0] grant_q, grant_d;
  logic             grant_valid_q, grant_valid_d;
  logic             expired_q, expired_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] pick;
  logic [3:0]       bcd_raw;

  assign pick = rr_pick(req, last_q);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    expired_d     = 1'b0;
    last_d        = last_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d       = GRANT;
          grant_d       = REQ_N'(1) << pick;
          grant_valid_d = 1'b1;
          last_d        = pick;
          cnt_d         = CNT_W'(1);
        end
      end
      GRANT: begin
        // last_q always names the current owner while in GRANT.
        if (!req[last_q] || cnt_q == CNT_W'(MAX_HOLD)) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          cnt_d         = '0;
          expired_d     = req[last_q];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      expired_q     <= 1'b0;
      last_q        <= IDX_W'(REQ_N - 1);
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      expired_q     <= expired_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
    end
  end

  one_hot_to_bcd u_enc (
    .onehot (grant_q),
    .bcd    (bcd_raw)
  );

  // The encoder is undefined for an all-zero grant, so mask it.
  assign grant_idx   = grant_valid_q ? bcd_raw : 4'b0000;
  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign expired     = expired_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: two instances (hold limits 2 and 4) share the
// same stimulus and are compared every cycle against an ownership model.
module tb_rr_onehot_arbiter;

  typedef struct {
    int owner;  // -1 when nobody holds the resource
    int held;
    int last;
    bit exp;
  } m_t;

  localparam m_t M_RST = '{owner: -1, held: 0, last: 7, exp: 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req = 8'h00;
  logic [7:0] g2, g4;
  logic [3:0] i2, i4;
  logic       v2, v4, e2, e4;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  m_t m2 = M_RST;
  m_t m4 = M_RST;

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .req(req),
    .grant(g2), .grant_idx(i2), .grant_valid(v2), .expired(e2)
  );

  rr_onehot_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .req(req),
    .grant(g4), .grant_idx(i4), .grant_valid(v4), .expired(e4)
  );

  function automatic m_t step(m_t s, logic [7:0] r, int lim);
    m_t n;
    int c;
    n = s;
    n.exp = 1'b0;
    if (s.owner < 0) begin
      if (r != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          c = (s.last + k) % 8;
          if (r[c]) begin
            n.owner = c;
            n.last  = c;
            n.held  = 1;
            break;
          end
        end
      end
    end else if (!r[s.owner]) begin
      n.owner = -1;
    end else if (s.held == lim) begin
      n.owner = -1;
      n.exp   = 1'b1;
    end else begin
      n.held = s.held + 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] m_grant(m_t s);
    return (s.owner < 0) ? 8'h00 : (8'h01 << s.owner);
  endfunction

  function automatic logic [7:0] m_idx(m_t s);
    return (s.owner < 0) ? 8'h00 : 8'(s.owner);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m2 <= M_RST;
      m4 <= M_RST;
    end else begin
      m2 <= step(m2, req, 2);
      m4 <= step(m4, req, 4);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("grant2",   g2,        m_grant(m2));
      chk("idx2",     8'(i2),    m_idx(m2));
      chk("valid2",   8'(v2),    8'(m2.owner >= 0));
      chk("expired2", 8'(e2),    8'(m2.exp));
      chk("onehot2",  8'($onehot0(g2)), 8'h01);
      chk("grant4",   g4,        m_grant(m4));
      chk("idx4",     8'(i4),    m_idx(m4));
      chk("valid4",   8'(v4),    8'(m4.owner >= 0));
      chk("expired4", 8'(e4),    8'(m4.exp));
      chk("onehot4",  8'($onehot0(g4)), 8'h01);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fair_g[7];
    logic [7:0] fair_e[7];
    logic [7:0] sole_g[6];
    logic [7:0] sole_e[6];
    fair_g = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h00, 8'h01};
    fair_e = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    sole_g = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h20};
    sole_e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};

    rst = 1'b1;
    req = 8'h00;
    tick();
    check_en = 1'b1;
    tick();
    chk("rst_grant", g4, 8'h00);
    chk("rst_valid", 8'(v4), 8'h00);
    rst = 1'b0;

    // idle with no requests
    repeat (5) tick();
    chk("idle_grant", g4, 8'h00);
    chk("idle_idx", 8'(i4), 8'h00);

    // single requester 3 for three cycles, then withdrawn
    req = 8'h08;
    tick();
    chk("r3_grant", g4, 8'h08);
    chk("r3_idx", 8'(i4), 8'h03);
    tick();
    tick();
    chk("r3_hold", g4, 8'h08);
    req = 8'h00;
    tick();
    chk("r3_release", g4, 8'h00);
    chk("r3_noexp", 8'(e4), 8'h00);
    repeat (3) tick();

    // fairness between 0 and 7 on the MAX_HOLD=2 instance
    pulse_reset();
    req = 8'h81;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("fair_grant", g2, fair_g[k]);
      chk("fair_exp", 8'(e2), fair_e[k]);
    end
    req = 8'h00;
    repeat (3) tick();

    // sole requester timeout on the MAX_HOLD=4 instance
    pulse_reset();
    req = 8'h20;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("sole_grant", g4, sole_g[k]);
      chk("sole_exp", 8'(e4), sole_e[k]);
    end
    chk("sole_idx", 8'(i4), 8'h05);
    req = 8'h00;
    repeat (3) tick();

    // no preemption of requester 6
    pulse_reset();
    req = 8'h40;
    tick();
    req = 8'hFF;
    tick();
    tick();
    chk("nopre_grant", g4, 8'h40);
    req = 8'hBF;
    tick();
    chk("nopre_dead", g4, 8'h00);
    tick();
    chk("nopre_next", g4, 8'h80);
    chk("nopre_idx", 8'(i4), 8'h07);
    req = 8'h7F;
    tick();
    tick();
    chk("nopre_wrap", g4, 8'h01);
    req = 8'h00;
    repeat (3) tick();

    // asynchronous reset while requester 2 holds the grant
    pulse_reset();
    req = 8'h04;
    tick();
    chk("ar_pre", g4, 8'h04);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_grant", g4, 8'h00);
    chk("ar_idx", 8'(i4), 8'h00);
    chk("ar_valid", 8'(v4), 8'h00);
    req = 8'hFF;
    tick();
    rst = 1'b0;
    tick();
    chk("ar_first", g4, 8'h01);
    chk("ar_first2", g2, 8'h01);

    // randomized traffic with occasional async resets
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: req = 8'($urandom);
        1: req = 8'h01 << $urandom_range(0, 7);
        2: req = req;
        default: req = 8'($urandom) & 8'($urandom);
      endcase
      if ($urandom_range(0, 199) == 0) begin
        #($urandom_range(1, 5));
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      tick();
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
